// File: rtl/multi_pulse_gen_pkg.sv
// Shared edge-mode encoding for the multi-channel pulse generator.
// Imported by the channel and top modules.
package multi_pulse_pkg;

  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t EDGE_OFF  = 2'b00;
  localparam edge_mode_t EDGE_RISE = 2'b01;
  localparam edge_mode_t EDGE_FALL = 2'b10;
  localparam edge_mode_t EDGE_BOTH = 2'b11;

endpackage

// File: rtl/multi_pulse_gen_ch.sv
// One channel: optional synchroniser, edge detect, pulse stretcher,
// sticky overrun and saturating event counter.
module pulse_gen_ch
  import multi_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 0,
  parameter int PW_W        = 4,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ch_in,
  input  edge_mode_t       edge_mode,
  input  logic [PW_W-1:0]  len,
  input  logic             retrig,
  input  logic             clr_cnt,
  output logic             pulse_out,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            s;
  logic            prev;
  logic            rise;
  logic            fall;
  logic            rise_en;
  logic            fall_en;
  logic            qual;
  logic [PW_W-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = ch_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sq;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          sq <= '0;
        end else begin
          sq[0] <= ch_in;
          for (int i = 1; i < SYNC_STAGES; i++)
            sq[i] <= sq[i-1];
        end
      end
      assign s = sq[SYNC_STAGES-1];
    end
  endgenerate

  assign rise    = s & ~prev;
  assign fall    = ~s & prev;
  assign rise_en = (edge_mode == EDGE_RISE)
                || (edge_mode == EDGE_BOTH);
  assign fall_en = (edge_mode == EDGE_FALL)
                || (edge_mode == EDGE_BOTH);
  assign qual    = (rise_en & rise) | (fall_en & fall);

  // pulse_out mirrors cnt != 0, so it doubles as the busy state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev      <= 1'b0;
      cnt       <= '0;
      pulse_out <= 1'b0;
      overrun   <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      prev <= s;
      if (qual && (!pulse_out || retrig)) begin
        cnt       <= len;
        pulse_out <= 1'b1;
      end else if (pulse_out) begin
        cnt       <= cnt - PW_W'(1);
        pulse_out <= (cnt != PW_W'(1));
      end
      if (clr_cnt) begin
        evt_cnt <= '0;
        overrun <= 1'b0;
      end else begin
        if (qual && (evt_cnt != CNT_MAX))
          evt_cnt <= evt_cnt + CNT_W'(1);
        if (qual && pulse_out && !retrig)
          overrun <= 1'b1;
      end
    end
  end

  assign busy = pulse_out;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel edge-to-pulse generator: per-channel instances
// sharing one clamped pulse length.
module multi_pulse_gen
  import multi_pulse_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 0,
  parameter int PW_W        = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       ch_in,
  input  logic [2*NUM_CH-1:0]     edge_mode,
  input  logic [PW_W-1:0]         pulse_len,
  input  logic                    retrig,
  input  logic                    clr_cnt,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       overrun,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt
);

  logic [PW_W-1:0] len_eff;

  assign len_eff = (pulse_len == '0) ? PW_W'(1) : pulse_len;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pulse_gen_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .PW_W        (PW_W),
        .CNT_W       (CNT_W)
      ) u_ch (
        .CLK       (CLK),
        .RST       (RST),
        .ch_in     (ch_in[i]),
        .edge_mode (edge_mode_t'(edge_mode[2*i +: 2])),
        .len       (len_eff),
        .retrig    (retrig),
        .clr_cnt   (clr_cnt),
        .pulse_out (pulse_out[i]),
        .busy      (busy[i]),
        .overrun   (overrun[i]),
        .evt_cnt   (evt_cnt[CNT_W*i +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench: two configs (SYNC 0 / CNT 8 and SYNC 2 / CNT 2);
// expectations queued per cycle at drive time, checked on negedge.
module tb_multi_pulse_gen;

  localparam int A = 0;
  localparam int B = 1;
  localparam int K_PUL = 0;
  localparam int K_BSY = 1;
  localparam int K_OVR = 2;
  localparam int K_CNT = 3;
  localparam int K_VEC = 4;

  typedef struct {
    int    cyc;
    int    d;
    int    k;
    int    ch;
    int    val;
    string tag;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ch_in_a, ch_in_b;
  logic [7:0]  mode_a, mode_b;
  logic [3:0]  len_a, len_b;
  logic        retrig_a, retrig_b;
  logic        clr_a, clr_b;
  logic [3:0]  pulse_a, busy_a, ovr_a;
  logic [3:0]  pulse_b, busy_b, ovr_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  multi_pulse_gen #(
    .NUM_CH(4), .SYNC_STAGES(0), .PW_W(4), .CNT_W(8)
  ) dut_a (
    .CLK(CLK), .RST(RST), .ch_in(ch_in_a),
    .edge_mode(mode_a), .pulse_len(len_a),
    .retrig(retrig_a), .clr_cnt(clr_a),
    .pulse_out(pulse_a), .busy(busy_a),
    .overrun(ovr_a), .evt_cnt(cnt_a)
  );

  multi_pulse_gen #(
    .NUM_CH(4), .SYNC_STAGES(2), .PW_W(4), .CNT_W(2)
  ) dut_b (
    .CLK(CLK), .RST(RST), .ch_in(ch_in_b),
    .edge_mode(mode_b), .pulse_len(len_b),
    .retrig(retrig_b), .clr_cnt(clr_b),
    .pulse_out(pulse_b), .busy(busy_b),
    .overrun(ovr_b), .evt_cnt(cnt_b)
  );

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  function automatic int obs(int d, int k, int ch);
    case (k)
      K_PUL: return d == B ? int'(pulse_b[ch]) : int'(pulse_a[ch]);
      K_BSY: return d == B ? int'(busy_b[ch]) : int'(busy_a[ch]);
      K_OVR: return d == B ? int'(ovr_b[ch]) : int'(ovr_a[ch]);
      K_CNT: return d == B ? int'(cnt_b[2*ch +: 2])
                           : int'(cnt_a[8*ch +: 8]);
      K_VEC: return d == B ? int'(pulse_b) : int'(pulse_a);
      default: return -1;
    endcase
  endfunction

  task automatic exp_at(int dly, int d, int k, int ch,
                        int val, string tag);
    exp_t e;
    e.cyc = cyc + dly;
    e.d   = d;
    e.k   = k;
    e.ch  = ch;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, obs(sb[i].d, sb[i].k, sb[i].ch), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b0;
    ch_in_a  = '0;
    ch_in_b  = '0;
    mode_a   = 8'b01_11_11_01;
    mode_b   = 8'b00_00_11_10;
    len_a    = 4'd1;
    len_b    = 4'd3;
    retrig_a = 1'b1;
    retrig_b = 1'b1;
    clr_a    = 1'b0;
    clr_b    = 1'b0;
    tick(3);
    chk("rst_pulse_a", int'(pulse_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_ovr_a", int'(ovr_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_pulse_b", int'(pulse_b), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    RST = 1'b1;
    tick(3);

    // rise, len 1, no sync
    ch_in_a[0] = 1'b1;
    exp_at(0, A, K_PUL, 0, 0, "s1_pre");
    exp_at(1, A, K_PUL, 0, 1, "s1_hi");
    exp_at(1, A, K_BSY, 0, 1, "s1_busy");
    exp_at(2, A, K_PUL, 0, 0, "s1_lo");
    exp_at(2, A, K_CNT, 0, 1, "s1_cnt");
    tick(4);
    ch_in_a[0] = 1'b0;
    exp_at(1, A, K_PUL, 0, 0, "s1_fall_nop");
    exp_at(2, A, K_PUL, 0, 0, "s1_fall_nop2");
    exp_at(3, A, K_CNT, 0, 1, "s1_cnt_fall");
    tick(4);

    // fall mode through 2-stage sync
    ch_in_b[0] = 1'b1;
    for (int d = 1; d <= 6; d++)
      exp_at(d, B, K_PUL, 0, 0, "s2_rise_nop");
    tick(8);
    ch_in_b[0] = 1'b0;
    exp_at(2, B, K_PUL, 0, 0, "s2_pre");
    for (int d = 3; d <= 5; d++)
      exp_at(d, B, K_PUL, 0, 1, "s2_hi");
    exp_at(6, B, K_PUL, 0, 0, "s2_end");
    exp_at(7, B, K_CNT, 0, 1, "s2_cnt");
    tick(8);

    // both edges, retrigger
    len_a = 4'd5;
    ch_in_a[1] = 1'b1;
    exp_at(0, A, K_PUL, 1, 0, "s3_pre");
    for (int d = 1; d <= 7; d++)
      exp_at(d, A, K_PUL, 1, 1, "s3_hi");
    exp_at(8, A, K_PUL, 1, 0, "s3_end");
    exp_at(8, A, K_CNT, 1, 2, "s3_cnt");
    exp_at(8, A, K_OVR, 1, 0, "s3_ovr");
    tick(2);
    ch_in_a[1] = 1'b0;
    tick(8);

    // no retrigger: overrun, then clear
    retrig_a = 1'b0;
    ch_in_a[2] = 1'b1;
    for (int d = 1; d <= 5; d++)
      exp_at(d, A, K_PUL, 2, 1, "s4_hi");
    exp_at(6, A, K_PUL, 2, 0, "s4_end");
    exp_at(6, A, K_OVR, 2, 1, "s4_ovr");
    exp_at(6, A, K_CNT, 2, 2, "s4_cnt");
    tick(2);
    ch_in_a[2] = 1'b0;
    tick(5);
    clr_a = 1'b1;
    exp_at(1, A, K_CNT, 2, 0, "s4_clr_cnt");
    exp_at(1, A, K_OVR, 2, 0, "s4_clr_ovr");
    exp_at(1, A, K_CNT, 1, 0, "s4_clr_other");
    tick(1);
    clr_a = 1'b0;
    tick(2);

    // edge on the last pulse cycle counts as busy
    len_a = 4'd2;
    ch_in_a[2] = 1'b1;
    exp_at(1, A, K_PUL, 2, 1, "s4b_hi1");
    exp_at(2, A, K_PUL, 2, 1, "s4b_hi2");
    exp_at(3, A, K_PUL, 2, 0, "s4b_ignored");
    exp_at(3, A, K_OVR, 2, 1, "s4b_ovr");
    exp_at(3, A, K_CNT, 2, 2, "s4b_cnt");
    tick(2);
    ch_in_a[2] = 1'b0;
    tick(4);
    retrig_a = 1'b1;

    // len 0 acts as 1; len change mid-pulse ignored
    len_a = 4'd0;
    ch_in_a[3] = 1'b1;
    exp_at(1, A, K_PUL, 3, 1, "len0_hi");
    exp_at(2, A, K_PUL, 3, 0, "len0_lo");
    tick(2);
    ch_in_a[3] = 1'b0;
    tick(3);
    len_a = 4'd4;
    ch_in_a[3] = 1'b1;
    for (int d = 1; d <= 4; d++)
      exp_at(d, A, K_PUL, 3, 1, "lenchg_hi");
    exp_at(5, A, K_PUL, 3, 0, "lenchg_end");
    tick(2);
    len_a = 4'd1;
    tick(5);
    ch_in_a[3] = 1'b0;
    tick(2);

    // simultaneous edges on all channels
    len_a = 4'd2;
    ch_in_a = 4'b1111;
    exp_at(1, A, K_VEC, 0, 15, "sim_rise1");
    exp_at(2, A, K_VEC, 0, 15, "sim_rise2");
    exp_at(3, A, K_VEC, 0, 0, "sim_rise_end");
    tick(5);
    ch_in_a = 4'b0000;
    exp_at(1, A, K_VEC, 0, 6, "sim_fall");
    tick(5);

    // 2-bit counter saturation, clear coincident with edge
    len_b = 4'd1;
    for (int n = 1; n <= 5; n++) begin
      ch_in_b[1] = ~ch_in_b[1];
      tick(4);
      if (n == 2) exp_at(0, B, K_CNT, 1, 2, "s5_two");
    end
    exp_at(0, B, K_CNT, 1, 3, "s5_sat");
    tick(1);
    ch_in_b[1] = ~ch_in_b[1];
    tick(2);
    clr_b = 1'b1;
    exp_at(1, B, K_CNT, 1, 0, "s5_clr_edge");
    exp_at(1, B, K_PUL, 1, 1, "s5_clr_pulse");
    tick(1);
    clr_b = 1'b0;
    exp_at(1, B, K_CNT, 1, 0, "s5_clr_hold");
    tick(3);

    // reset mid-pulse, input high at release
    len_a = 4'd8;
    ch_in_a[0] = 1'b1;
    exp_at(1, A, K_PUL, 0, 1, "s6_pre");
    tick(3);
    RST = 1'b0;
    #1;
    chk("s6_rst_pulse", int'(pulse_a), 0);
    chk("s6_rst_busy", int'(busy_a), 0);
    chk("s6_rst_ovr", int'(ovr_a), 0);
    chk("s6_rst_cnt_a", int'(cnt_a), 0);
    chk("s6_rst_cnt_b", int'(cnt_b), 0);
    tick(1);
    RST = 1'b1;
    exp_at(0, A, K_PUL, 0, 0, "s6_rel_pre");
    exp_at(1, A, K_PUL, 0, 1, "s6_rel_hi");
    exp_at(1, A, K_CNT, 0, 1, "s6_rel_cnt");
    exp_at(8, A, K_PUL, 0, 1, "s6_rel_last");
    exp_at(9, A, K_PUL, 0, 0, "s6_rel_end");
    tick(11);

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
